// File: rtl/uart_cmd_wrapper.sv
// uart_cmd_wrapper
// Serial front end of the knight controller. It receives 8N1 bytes on RX,
// pairs them into 16-bit commands (high byte first) and serialises 8-bit
// responses onto TX. The receive and transmit paths are independent, so
// the block runs full duplex.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   RX           serial input; idles high; asynchronous to clk
//   TX           serial output; idles high
//   cmd[15:0]    assembled command {high_byte, low_byte}
//   cmd_rdy      a complete command is valid on cmd
//   clr_cmd_rdy  consumer pulse that clears cmd_rdy
//   trmt         pulse that starts transmission of resp
//   resp[7:0]    response byte, sampled on the trmt cycle
//   tx_done      the last transmission has completed
module uart_cmd_wrapper #(
    parameter int BAUD_DIV    = 2604,
    parameter int TIMEOUT_CYC = 131072
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        trmt,
    input  logic [7:0]  resp,
    output logic        tx_done
);
    localparam int BW = $clog2(BAUD_DIV);
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [BW-1:0] BAUD_HALF = BW'(BAUD_DIV / 2);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYC);

    typedef enum logic {RX_IDLE, RX_RECV}     rx_state_e;
    typedef enum logic {WAIT_HIGH, WAIT_LOW}  asm_state_e;
    typedef enum logic {TX_IDLE, TX_XMIT}     tx_state_e;

    // ---------------- RX synchroniser + edge flop ----------------
    logic rx_ff1_q, rx_ff2_q, rx_prev_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_ff1_q  <= 1'b1;
            rx_ff2_q  <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_ff1_q  <= RX;
            rx_ff2_q  <= rx_ff1_q;
            rx_prev_q <= rx_ff2_q;
        end
    end

    logic rx_fall, start_det;
    rx_state_e rx_state_q;
    assign rx_fall   = rx_prev_q & ~rx_ff2_q;
    // Only an edge seen while idle is a frame start; edges inside a frame are data.
    assign start_det = (rx_state_q == RX_IDLE) && rx_fall;

    // ---------------- Receiver ----------------
    logic [BW-1:0] rx_baud_q;
    logic [3:0]    rx_bcnt_q;
    logic [7:0]    rx_shift_q;
    logic          rx_rdy_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state_q <= RX_IDLE;
            rx_baud_q  <= '0;
            rx_bcnt_q  <= '0;
            rx_shift_q <= '0;
            rx_rdy_q   <= 1'b0;
        end else begin
            rx_rdy_q <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_fall) begin
                        rx_state_q <= RX_RECV;
                        rx_bcnt_q  <= 4'd0;
                        rx_baud_q  <= BAUD_HALF;  // first sample lands mid start bit
                    end
                end
                RX_RECV: begin
                    if (rx_baud_q == '0) begin
                        rx_baud_q <= BAUD_LAST;
                        if (rx_bcnt_q == 4'd0 && rx_ff2_q) begin
                            rx_state_q <= RX_IDLE;       // start bit was a glitch
                        end else if (rx_bcnt_q == 4'd9) begin
                            rx_state_q <= RX_IDLE;
                            rx_rdy_q   <= rx_ff2_q;      // bad stop bit drops the byte
                        end else begin
                            if (rx_bcnt_q != 4'd0)
                                rx_shift_q <= {rx_ff2_q, rx_shift_q[7:1]};
                            rx_bcnt_q <= rx_bcnt_q + 4'd1;
                        end
                    end else begin
                        rx_baud_q <= rx_baud_q - 1'b1;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    // ---------------- Command assembler ----------------
    asm_state_e    asm_state_q;
    logic [TW-1:0] tmo_q;
    logic [15:0]   cmd_q;
    logic          cmd_rdy_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            asm_state_q <= WAIT_HIGH;
            tmo_q       <= '0;
            cmd_q       <= '0;
            cmd_rdy_q   <= 1'b0;
        end else begin
            case (asm_state_q)
                WAIT_HIGH: begin
                    if (rx_rdy_q) begin
                        cmd_q[15:8] <= rx_shift_q;
                        tmo_q       <= '0;
                        asm_state_q <= WAIT_LOW;
                    end
                end
                WAIT_LOW: begin
                    if (rx_rdy_q) begin
                        cmd_q[7:0]  <= rx_shift_q;
                        asm_state_q <= WAIT_HIGH;
                    end else if (tmo_q == TMO_LIMIT) begin
                        asm_state_q <= WAIT_HIGH;  // high byte is stale
                    end else if (rx_state_q == RX_IDLE) begin
                        tmo_q <= tmo_q + 1'b1;     // time spent receiving doesn't count
                    end
                end
                default: asm_state_q <= WAIT_HIGH;
            endcase

            // Set has priority over either clear source.
            if (asm_state_q == WAIT_LOW && rx_rdy_q)
                cmd_rdy_q <= 1'b1;
            else if (clr_cmd_rdy || start_det)
                cmd_rdy_q <= 1'b0;
        end
    end

    assign cmd     = cmd_q;
    assign cmd_rdy = cmd_rdy_q;

    // ---------------- Transmitter ----------------
    tx_state_e     tx_state_q;
    logic [BW-1:0] tx_baud_q;
    logic [3:0]    tx_bcnt_q;
    logic [9:0]    tx_shift_q;
    logic          tx_done_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_baud_q  <= '0;
            tx_bcnt_q  <= '0;
            tx_shift_q <= '1;  // line idles high
            tx_done_q  <= 1'b0;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    if (trmt) begin
                        tx_shift_q <= {1'b1, resp, 1'b0};
                        tx_baud_q  <= BAUD_LAST;
                        tx_bcnt_q  <= 4'd0;
                        tx_done_q  <= 1'b0;
                        tx_state_q <= TX_XMIT;
                    end
                end
                TX_XMIT: begin
                    if (tx_baud_q == '0) begin
                        tx_baud_q  <= BAUD_LAST;
                        tx_shift_q <= {1'b1, tx_shift_q[9:1]};
                        if (tx_bcnt_q == 4'd9) begin
                            tx_state_q <= TX_IDLE;
                            tx_done_q  <= 1'b1;
                        end else begin
                            tx_bcnt_q <= tx_bcnt_q + 4'd1;
                        end
                    end else begin
                        tx_baud_q <= tx_baud_q - 1'b1;
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    assign TX      = tx_shift_q[0];
    assign tx_done = tx_done_q;

endmodule

// File: doc/uart_cmd_wrapper.md
# uart_cmd_wrapper

Serial front end of the knight controller. It receives 8N1 UART bytes from the remote commander, pairs them into 16-bit commands (high byte first), and presents each command to the command processor with a `cmd_rdy`/`clr_cmd_rdy` handshake. It also serialises the processor's 8-bit response, such as 0xA5, back onto TX. It sits between the chip's RX/TX pins and the command processor.

## Interface
- `BAUD_DIV`, 2604: clocks per bit period (19200 baud at 50 MHz); the bench uses 16.
- `TIMEOUT_CYC`, 131072: maximum idle clocks allowed between the high-byte stop bit and the low-byte start bit.

- `clk` in 1: system clock.
- `rst_n` in 1: reset, synchronous and active-low.
- `RX` in 1: serial input; idles high; asynchronous to `clk`.
- `TX` out 1: serial output; idles high.
- `cmd` out 16: assembled command, `{high_byte, low_byte}`.
- `cmd_rdy` out 1: a complete command is valid on `cmd`.
- `clr_cmd_rdy` in 1: single-cycle pulse from the consumer; clears `cmd_rdy`.
- `trmt` in 1: single-cycle pulse; starts transmission of `resp`.
- `resp` in 8: response byte; sampled on the `trmt` cycle.
- `tx_done` out 1: the last transmission has completed.

## Operation
- **RX synchroniser:** two flops, both reset to 1. All receive logic uses the synchronised value only.
- **Receiver FSM `IDLE -> RECV`:**
  - In `IDLE`, a synchronised 1->0 edge starts a frame. The bit counter loads 0; the baud counter loads `BAUD_DIV/2`, so the first sample falls mid start bit.
  - Each later sample is `BAUD_DIV` clocks after the previous one. 10 samples are taken (start, 8 data LSB-first, stop), then the FSM returns to `IDLE`.
  - Stop sample 1: byte valid, producing a one-cycle internal `rx_rdy`.
  - Stop sample 0: framing error; byte discarded and assembler unaffected.
  - Start sample 1 (glitch): abort to `IDLE`.
- **Assembler FSM `WAIT_HIGH -> WAIT_LOW`:**
  - In `WAIT_HIGH`, `rx_rdy` stores the byte in the high register, clears the timeout counter, and moves to `WAIT_LOW`.
  - In `WAIT_LOW`, `rx_rdy` stores the low register, sets `cmd_rdy`, and returns to `WAIT_HIGH`.
  - In `WAIT_LOW`, the timeout counter runs only while the receiver is in `IDLE`. At `TIMEOUT_CYC` the FSM returns to `WAIT_HIGH` and the stored high byte is considered stale.
- **`cmd_rdy`:**
  - Set on low-byte completion.
  - Cleared by `clr_cmd_rdy`, or by detection of the next start bit, whichever comes first.
  - If set and `clr_cmd_rdy` occur in the same cycle, set wins.
- **`cmd` stability:** `cmd` is a direct register output. It changes only when a high or low byte completes, so it is stable whenever `cmd_rdy` is 1.
- **Transmitter FSM `IDLE -> XMIT`:**
  - In `IDLE`, `trmt` loads `{1, resp, 0}` into a 10-bit shifter, clears `tx_done`, and enters `XMIT`.
  - `TX` is the shifter LSB. The shifter shifts every `BAUD_DIV` clocks.
  - After 10 bit periods the FSM returns to `IDLE` and sets `tx_done`.
  - `trmt` in `XMIT` is ignored; `resp` is not re-sampled.
- Receiver and transmitter are fully independent, so full duplex is allowed.

## Timing
- **Reset values:** `TX`=1, `cmd`=0x0000, `cmd_rdy`=0, `tx_done`=0; all FSMs in their first state; counters 0. A reset mid-frame aborts both directions immediately with no partial output.
- **Start detection latency:** 3 clocks from the RX falling edge (2 synchroniser flops plus the edge flop).
- **`cmd_rdy` rise:** 1 clock after the mid-stop-bit sample of the low byte. That is about `3 + BAUD_DIV/2 + 9*BAUD_DIV + 1` clocks after that byte's RX falling edge, ±1 clock.
- **`cmd_rdy` fall:** the clock after `clr_cmd_rdy` is sampled high.
- **TX start:** `TX` goes low the clock after `trmt`.
- **TX frame:** each bit is held exactly `BAUD_DIV` clocks. `tx_done` rises `10*BAUD_DIV` clocks after `TX` first falls.
- **Counter widths:** baud counter is `$clog2(BAUD_DIV)` bits; bit counters are 4 bits; timeout counter is `$clog2(TIMEOUT_CYC)+1` bits.
- **Counter wrap:** counters reload and never wrap.

## Test plan
All scenarios use `BAUD_DIV`=16 and `TIMEOUT_CYC`=1000.
- **Basic command:** send 0x20 then 0x00 back-to-back -> `cmd`=0x2000 and `cmd_rdy`=1 within one clock of the expected rise; pulse `clr_cmd_rdy` -> `cmd_rdy`=0 the next clock, `cmd` still 0x2000.
- **Second command, no clear:** send 0x43, 0xF2 without clearing -> `cmd_rdy` drops at the 0x43 start bit, then `cmd`=0x43F2 with `cmd_rdy`=1.
- **Timeout recovery:** send 0x43, idle 1200 clocks, send 0x12, 0x34 -> exactly one `cmd_rdy`, with `cmd`=0x1234, never 0x4312.
- **Framing error:** send 0x55 with the stop bit forced to 0, then 0xAB, 0xCD -> `cmd`=0xABCD.
- **Response transmit:** `trmt` with `resp`=0xA5 -> `TX` sequence 0,1,0,1,0,0,1,0,1,1 at 16 clocks per bit; `tx_done` at clock 160. A second `trmt` at clock 40 with `resp`=0x00 changes nothing.
- **Reset mid-operation:** assert `rst_n`=0 mid-byte in both directions -> next clock `TX`=1, `cmd_rdy`=0, `cmd`=0; a following clean 0x12, 0x34 gives `cmd`=0x1234.
